// File: rtl/slurm16_memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | slurm16_memory_arbiter: N-channel valid/ready arbiter onto one SRAM port |
// | Rev 1.0 - round-robin / fixed priority with bounded lock bursts          |
// +--------------------------------------------------------------------------+
module slurm16_memory_arbiter #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16,
    parameter int CHANNELS     = 4,
    parameter int ROUND_ROBIN  = 1,
    parameter int MAX_BURST    = 8
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [CHANNELS-1:0]              req_valid,
    input  logic [CHANNELS-1:0]              req_wr,
    input  logic [CHANNELS-1:0]              req_lock,
    input  logic [CHANNELS*ADDRESS_BITS-1:0] req_address,
    input  logic [CHANNELS*BITS-1:0]         req_data,
    output logic [CHANNELS-1:0]              req_ready,
    output logic [BITS-1:0]                  rd_data,
    output logic [CHANNELS-1:0]              rd_valid,
    output logic [ADDRESS_BITS-1:0]          mem_address,
    output logic [BITS-1:0]                  mem_wdata,
    output logic                             mem_en,
    output logic                             mem_wr,
    input  logic [BITS-1:0]                  mem_rdata,
    output logic [$clog2(CHANNELS)-1:0]      owner,
    output logic                             locked
);

    localparam int IW = $clog2(CHANNELS);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        S_ARB   = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       ptr_q;
    logic [CW-1:0]       count_q;
    logic [IW-1:0]       owner_q;
    logic [CHANNELS-1:0] rd_valid_q;

    logic                win_any;
    logic [IW-1:0]       win_idx;
    logic                own_ok;
    logic                gnt_any;
    logic [IW-1:0]       gnt_idx;
    logic [CHANNELS-1:0] grant;
    logic [IW-1:0]       ptr_d;
    int                  idx;

    // First valid channel, searched upward from the pointer (or from 0 in fixed mode)
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = (ROUND_ROBIN != 0) ? (int'(ptr_q) + k) % CHANNELS : k;
            if (!win_any && req_valid[IW'(idx)]) begin
                win_any = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    assign own_ok = req_valid[owner_q] & req_lock[owner_q] & (count_q < CW'(MAX_BURST));

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        grant   = '0;
        if (!RST) begin
            if (state_q == S_ARB) begin
                gnt_any = win_any;
                gnt_idx = win_idx;
            end else begin
                gnt_any = own_ok;
                gnt_idx = owner_q;
            end
        end
        if (gnt_any) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign ptr_d       = IW'((int'(gnt_idx) + 1) % CHANNELS);
    assign req_ready   = grant;
    assign mem_en      = gnt_any;
    assign mem_wr      = gnt_any & req_wr[gnt_idx];
    assign mem_address = gnt_any ? req_address[gnt_idx*ADDRESS_BITS +: ADDRESS_BITS] : '0;
    assign mem_wdata   = gnt_any ? req_data[gnt_idx*BITS +: BITS] : '0;
    assign rd_data     = mem_rdata;
    assign rd_valid    = rd_valid_q;
    assign owner       = owner_q;
    assign locked      = (state_q == S_OWNED);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_ARB;
            ptr_q      <= '0;
            count_q    <= '0;
            owner_q    <= '0;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= grant & {CHANNELS{~mem_wr}};
            if (gnt_any && ROUND_ROBIN != 0) begin
                ptr_q <= ptr_d;
            end
            case (state_q)
                S_ARB: begin
                    if (gnt_any && req_lock[gnt_idx]) begin
                        state_q <= S_OWNED;
                        owner_q <= gnt_idx;
                        count_q <= CW'(1);
                    end
                end
                default: begin
                    if (gnt_any) begin
                        count_q <= count_q + CW'(1);
                    end else begin
                        // Burst limit hit: hand priority to the channel after the owner
                        if (ROUND_ROBIN != 0 && req_valid[owner_q] && req_lock[owner_q]) begin
                            ptr_q <= IW'((int'(owner_q) + 1) % CHANNELS);
                        end
                        state_q <= S_ARB;
                        owner_q <= '0;
                        count_q <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slurm16_memory_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_slurm16_memory_arbiter: directed vector bench for the memory arbiter  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_slurm16_memory_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req_valid, req_wr, req_lock;
    logic [63:0] req_address;
    logic [63:0] req_data;
    logic [3:0]  req_ready, rd_valid;
    logic [15:0] rd_data, mem_address, mem_wdata, mem_rdata;
    logic        mem_en, mem_wr, locked;
    logic [1:0]  owner;

    logic [3:0]  f_valid, f_ready, f_rd_valid;
    logic [15:0] f_rd_data, f_mem_address, f_mem_wdata, f_mem_rdata;
    logic        f_mem_en, f_mem_wr, f_locked;
    logic [1:0]  f_owner;

    int n_pass  = 0;
    int n_total = 0;

    slurm16_memory_arbiter dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_wr(req_wr), .req_lock(req_lock),
        .req_address(req_address), .req_data(req_data), .req_ready(req_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
        .owner(owner), .locked(locked)
    );

    slurm16_memory_arbiter #(.ROUND_ROBIN(0)) dut_fixed (
        .CLK(CLK), .RST(RST), .req_valid(f_valid), .req_wr(req_wr), .req_lock(req_lock),
        .req_address(req_address), .req_data(req_data), .req_ready(f_ready),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .mem_address(f_mem_address),
        .mem_wdata(f_mem_wdata), .mem_en(f_mem_en), .mem_wr(f_mem_wr), .mem_rdata(f_mem_rdata),
        .owner(f_owner), .locked(f_locked)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: unwritten locations read back as addr ^ 16'hA5C3
    logic [15:0] sram [int];
    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_wr) sram[int'(mem_address)] = mem_wdata;
            else mem_rdata <= sram.exists(int'(mem_address)) ? sram[int'(mem_address)]
                                                              : (mem_address ^ 16'hA5C3);
        end
    end

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [3:0] ready;
        logic [3:0] rdv;
        logic       lk;
        logic [1:0] own;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r,
                       input logic [3:0] rv, input logic lk, input logic [1:0] ow);
        vec_t e;
        e.valid = v; e.lock = l; e.ready = r; e.rdv = rv; e.lk = lk; e.own = ow;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic default_addr();
        for (int i = 0; i < 4; i++) begin
            req_address[i*16 +: 16] = 16'h0100 + 16'(i);
            req_data[i*16 +: 16]    = 16'hD000 + 16'(i);
        end
    endtask

    initial begin
        RST = 1'b1; req_valid = 4'hF; req_wr = '0; req_lock = '0; f_valid = '0;
        f_mem_rdata = '0; mem_rdata = '0;
        default_addr();

        // Round robin, all valid reads
        add(4'hF, 4'h0, 4'b0001, 4'b0000, 0, 0);
        add(4'hF, 4'h0, 4'b0010, 4'b0001, 0, 0);
        add(4'hF, 4'h0, 4'b0100, 4'b0010, 0, 0);
        add(4'hF, 4'h0, 4'b1000, 4'b0100, 0, 0);
        add(4'hF, 4'h0, 4'b0001, 4'b1000, 0, 0);
        add(4'hF, 4'h0, 4'b0010, 4'b0001, 0, 0);
        add(4'hF, 4'h0, 4'b0100, 4'b0010, 0, 0);
        add(4'hF, 4'h0, 4'b1000, 4'b0100, 0, 0);
        add(4'h0, 4'h0, 4'b0000, 4'b1000, 0, 0);
        // Channel 2 locked burst of 8 while channel 0 waits
        add(4'b0100, 4'b0100, 4'b0100, 4'b0000, 0, 0);
        for (int i = 0; i < 7; i++)
            add(4'b0101, 4'b0100, 4'b0100, 4'b0100, 1, 2);
        add(4'b0101, 4'b0100, 4'b0000, 4'b0100, 1, 2);
        add(4'b0101, 4'b0100, 4'b0001, 4'b0000, 0, 0);
        add(4'h0, 4'h0, 4'b0000, 4'b0001, 0, 0);
        // Channel 1 locks for 3 grants then drops lock, channel 3 waiting
        add(4'b1010, 4'b0010, 4'b0010, 4'b0000, 0, 0);
        add(4'b1010, 4'b0010, 4'b0010, 4'b0010, 1, 1);
        add(4'b1010, 4'b0010, 4'b0010, 4'b0010, 1, 1);
        add(4'b1010, 4'b0000, 4'b0000, 4'b0010, 1, 1);
        add(4'b1010, 4'b0000, 4'b1000, 4'b0000, 0, 0);
        add(4'h0, 4'h0, 4'b0000, 4'b1000, 0, 0);

        // Reset state, with requests asserted
        @(negedge CLK); @(negedge CLK);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset mem_en", 32'(mem_en), 32'h0);
        chk("reset rd_valid", 32'(rd_valid), 32'h0);
        chk("reset locked", 32'(locked), 32'h0);
        chk("reset owner", 32'(owner), 32'h0);
        RST = 1'b0; req_valid = '0;

        foreach (tbl[n]) begin
            @(negedge CLK);
            req_valid = tbl[n].valid; req_lock = tbl[n].lock;
            #1;
            chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(tbl[n].ready));
            chk($sformatf("row%0d mem_en", n), 32'(mem_en), 32'(|tbl[n].ready));
            chk($sformatf("row%0d mem_address", n), 32'(mem_address),
                (|tbl[n].ready) ? 32'(16'h0100 + 16'(oh2i(tbl[n].ready))) : 32'h0);
            chk($sformatf("row%0d rd_valid", n), 32'(rd_valid), 32'(tbl[n].rdv));
            chk($sformatf("row%0d locked", n), 32'(locked), 32'(tbl[n].lk));
            chk($sformatf("row%0d owner", n), 32'(owner), 32'(tbl[n].own));
            if (|tbl[n].rdv)
                chk($sformatf("row%0d rd_data", n), 32'(rd_data),
                    32'((16'h0100 + 16'(oh2i(tbl[n].rdv))) ^ 16'hA5C3));
        end

        // Write on channel 0 then read the same address on channel 2
        @(negedge CLK);
        req_address[15:0] = 16'h1234; req_data[15:0] = 16'hBEEF;
        req_address[47:32] = 16'h1234;
        req_valid = 4'b0001; req_wr = 4'b0001; req_lock = '0;
        #1;
        chk("wr req_ready", 32'(req_ready), 32'h1);
        chk("wr mem_wr", 32'(mem_wr), 32'h1);
        chk("wr mem_address", 32'(mem_address), 32'h1234);
        chk("wr mem_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge CLK);
        req_valid = 4'b0100; req_wr = '0;
        #1;
        chk("rd req_ready", 32'(req_ready), 32'h4);
        chk("rd mem_wr", 32'(mem_wr), 32'h0);
        chk("wr no rd_valid", 32'(rd_valid), 32'h0);
        @(negedge CLK);
        req_valid = '0;
        #1;
        chk("rd rd_valid", 32'(rd_valid), 32'h4);
        chk("rd rd_data", 32'(rd_data), 32'hBEEF);
        default_addr();

        // Asynchronous reset while owned with a read in flight
        @(negedge CLK);
        req_valid = 4'b0010; req_lock = 4'b0010;
        #1;
        chk("rst seq first grant", 32'(req_ready), 32'h2);
        @(negedge CLK);
        #1;
        chk("rst seq owned grant", 32'(req_ready), 32'h2);
        chk("rst seq locked", 32'(locked), 32'h1);
        chk("rst seq owner", 32'(owner), 32'h1);
        @(posedge CLK);
        #1;
        chk("rst seq read in flight", 32'(rd_valid), 32'h2);
        RST = 1'b1;
        #1;
        chk("mid rst rd_valid", 32'(rd_valid), 32'h0);
        chk("mid rst locked", 32'(locked), 32'h0);
        chk("mid rst owner", 32'(owner), 32'h0);
        chk("mid rst req_ready", 32'(req_ready), 32'h0);
        @(negedge CLK);
        RST = 1'b0; req_valid = 4'hF; req_lock = '0;
        #1;
        chk("post rst rr from 0", 32'(req_ready), 32'h1);
        chk("post rst rd_valid", 32'(rd_valid), 32'h0);
        @(negedge CLK);
        req_valid = '0;

        // Fixed priority instance
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            f_valid = 4'b1010;
            #1;
            chk($sformatf("fixed ch1 wins %0d", i), 32'(f_ready), 32'h2);
        end
        @(negedge CLK);
        f_valid = 4'b1000;
        #1;
        chk("fixed ch3 after drop", 32'(f_ready), 32'h8);
        @(negedge CLK);
        f_valid = 4'b1010;
        #1;
        chk("fixed ch1 again", 32'(f_ready), 32'h2);
        @(negedge CLK);
        f_valid = 4'b0011;
        #1;
        chk("fixed ch0 highest", 32'(f_ready), 32'h1);
        @(negedge CLK);
        f_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
